// File: rtl/fifo_drain.sv
// rtl/fifo_drain.sv - read-side FIFO consumer feeding a valid/ready stream; FIFO_DRAIN_CNT_EN enables the delivered-word counter
module fifo_drain #(
    parameter int DWIDTH = 8,
    parameter int CWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              drain_en,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DWIDTH-1:0] fifo_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic [CWIDTH-1:0] word_cnt
);

    logic [1:0]        occ_q, occ_d;
    logic              pend_q;
    logic [DWIDTH-1:0] buf0_q, buf0_d;
    logic [DWIDTH-1:0] buf1_q, buf1_d;
    logic              pop;
    logic              has_space;
    logic [1:0]        slot;

    assign pop       = out_valid & out_ready;
    // A slot is free if the buffer plus the in-flight read leaves room, or the head leaves this cycle.
    assign has_space = ((occ_q + {1'b0, pend_q}) < 2'd2) | pop;
    assign fifo_rd_en = !rst & drain_en & !fifo_empty & has_space;

    assign out_valid = (occ_q != 2'd0);
    assign out_data  = buf0_q;

    // The captured word lands in the first slot left free after this cycle's pop.
    assign slot = occ_q - {1'b0, pop};

    // Next-state for the two-entry buffer: shift on pop, then place the returning FIFO word.
    always_comb begin
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        if (pop) begin
            buf0_d = buf1_q;
        end
        if (pend_q) begin
            if (slot == 2'd0) begin
                buf0_d = fifo_rdata;
            end else begin
                buf1_d = fifo_rdata;
            end
        end
        occ_d = occ_q + {1'b0, pend_q} - {1'b0, pop};
    end

    // Buffer, occupancy and in-flight read tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q  <= 2'd0;
            pend_q <= 1'b0;
            buf0_q <= '0;
            buf1_q <= '0;
        end else begin
            occ_q  <= occ_d;
            pend_q <= fifo_rd_en;
            buf0_q <= buf0_d;
            buf1_q <= buf1_d;
        end
    end

`ifdef FIFO_DRAIN_CNT_EN
    logic [CWIDTH-1:0] cnt_q;

    // Delivered-word counter, wraps naturally at 2^CWIDTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (pop) begin
            cnt_q <= cnt_q + CWIDTH'(1);
        end
    end

    assign word_cnt = cnt_q;
`else
    assign word_cnt = '0;
`endif

    // Space accounting must never let the buffer exceed its two entries.
    assert property (@(posedge clk) disable iff (rst) (occ_q <= 2'd2));

endmodule
